// File: rtl/sd_block_responder_if.sv
// rtl/sd_block_responder_if.sv - requester/backing-store bus bundle for sd_block_responder
interface sd_block_responder_if;
    // requester side
    logic [2:0]  sd_rd;
    logic [2:0]  sd_wr;
    logic [31:0] sd_lba0;
    logic [31:0] sd_lba1;
    logic [31:0] sd_lba2;
    logic [31:0] img_blocks0;
    logic [31:0] img_blocks1;
    logic [31:0] img_blocks2;
    logic [7:0]  sd_buff_din0;
    logic [7:0]  sd_buff_din1;
    logic [7:0]  sd_buff_din2;
    logic [2:0]  sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    // backing-store side
    logic        img_req;
    logic        img_we;
    logic [1:0]  img_drive;
    logic [31:0] img_addr;
    logic [7:0]  img_wdata;
    logic        img_ack;
    logic [7:0]  img_rdata;
    logic        busy;

    modport master (
        input  sd_rd, sd_wr, sd_lba0, sd_lba1, sd_lba2,
        input  img_blocks0, img_blocks1, img_blocks2,
        input  sd_buff_din0, sd_buff_din1, sd_buff_din2,
        input  img_ack, img_rdata,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output img_req, img_we, img_drive, img_addr, img_wdata, busy
    );

    modport slave (
        output sd_rd, sd_wr, sd_lba0, sd_lba1, sd_lba2,
        output img_blocks0, img_blocks1, img_blocks2,
        output sd_buff_din0, sd_buff_din1, sd_buff_din2,
        output img_ack, img_rdata,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  img_req, img_we, img_drive, img_addr, img_wdata, busy
    );
endinterface

// File: rtl/sd_block_responder.sv
// rtl/sd_block_responder.sv - serves 512-byte block reads/writes for three drives against a backing store
module sd_block_responder #(
    parameter int ACK_DELAY = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    sd_block_responder_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK_WAIT,
        S_RD_FETCH,
        S_RD_STROBE,
        S_WR_ADDR,
        S_WR_STORE,
        S_RELEASE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_drive;
    logic        r_op_rd;
    logic        r_in_range;
    logic [22:0] r_lba_base;
    logic [8:0]  r_index;
    logic [3:0]  r_delay;
    logic [2:0]  r_ack;
    logic [8:0]  r_buff_addr;
    logic [7:0]  r_buff_dout;
    logic        r_buff_wr;
    logic        r_img_req;
    logic        r_img_we;
    logic [1:0]  r_img_drive;
    logic [31:0] r_img_addr;
    logic [7:0]  r_img_wdata;
    logic        r_busy;

    logic [2:0]  w_req;
    logic [1:0]  w_sel_drive;
    logic        w_sel_rd;
    logic [31:0] w_sel_lba;
    logic [31:0] w_sel_blocks;
    logic [7:0]  w_din;
    logic        w_drv_active;
    logic        w_last;
    logic [8:0]  w_index_next;

    assign w_req        = bus.sd_rd | bus.sd_wr;
    assign w_last       = (r_index == 9'd511);
    assign w_index_next = r_index + 9'd1;

    // Lowest-index requesting drive wins; its lba/size/op are what gets latched.
    always_comb begin
        w_sel_drive  = 2'd0;
        w_sel_rd     = bus.sd_rd[0];
        w_sel_lba    = bus.sd_lba0;
        w_sel_blocks = bus.img_blocks0;
        if (!w_req[0] && w_req[1]) begin
            w_sel_drive  = 2'd1;
            w_sel_rd     = bus.sd_rd[1];
            w_sel_lba    = bus.sd_lba1;
            w_sel_blocks = bus.img_blocks1;
        end else if (!w_req[0] && !w_req[1]) begin
            w_sel_drive  = 2'd2;
            w_sel_rd     = bus.sd_rd[2];
            w_sel_lba    = bus.sd_lba2;
            w_sel_blocks = bus.img_blocks2;
        end
    end

    // Per-drive views of the latched drive: buffer read data and its request level.
    always_comb begin
        w_din        = 8'h00;
        w_drv_active = 1'b0;
        case (r_drive)
            2'd0: begin
                w_din        = bus.sd_buff_din0;
                w_drv_active = bus.sd_rd[0] | bus.sd_wr[0];
            end
            2'd1: begin
                w_din        = bus.sd_buff_din1;
                w_drv_active = bus.sd_rd[1] | bus.sd_wr[1];
            end
            2'd2: begin
                w_din        = bus.sd_buff_din2;
                w_drv_active = bus.sd_rd[2] | bus.sd_wr[2];
            end
            default: begin
                w_din        = 8'h00;
                w_drv_active = 1'b0;
            end
        endcase
    end

    // Transfer sequencer; every bus output is a register updated here.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drive     <= 2'd0;
            r_op_rd     <= 1'b0;
            r_in_range  <= 1'b0;
            r_lba_base  <= 23'd0;
            r_index     <= 9'd0;
            r_delay     <= 4'd0;
            r_ack       <= 3'b000;
            r_buff_addr <= 9'd0;
            r_buff_dout <= 8'h00;
            r_buff_wr   <= 1'b0;
            r_img_req   <= 1'b0;
            r_img_we    <= 1'b0;
            r_img_drive <= 2'd0;
            r_img_addr  <= 32'd0;
            r_img_wdata <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_drive     <= w_sel_drive;
                        r_img_drive <= w_sel_drive;
                        r_op_rd     <= w_sel_rd;
                        r_in_range  <= (w_sel_lba < w_sel_blocks);
                        r_lba_base  <= w_sel_lba[22:0];
                        r_ack       <= 3'b001 << w_sel_drive;
                        r_index     <= 9'd0;
                        r_delay     <= 4'(ACK_DELAY);
                        r_busy      <= 1'b1;
                        r_state     <= S_ACK_WAIT;
                    end
                end

                S_ACK_WAIT: begin
                    if (r_delay <= 4'd1) begin
                        r_delay <= 4'd0;
                        if (r_op_rd) begin
                            r_img_req  <= r_in_range;
                            r_img_we   <= 1'b0;
                            r_img_addr <= {r_lba_base, r_index};
                            r_state    <= S_RD_FETCH;
                        end else begin
                            r_buff_addr <= r_index;
                            r_state     <= S_WR_ADDR;
                        end
                    end else begin
                        r_delay <= r_delay - 4'd1;
                    end
                end

                S_RD_FETCH: begin
                    // Out-of-range blocks read back as zeros without touching the store.
                    if (!r_in_range) begin
                        r_buff_dout <= 8'h00;
                        r_buff_addr <= r_index;
                        r_buff_wr   <= 1'b1;
                        r_state     <= S_RD_STROBE;
                    end else if (bus.img_ack) begin
                        r_img_req   <= 1'b0;
                        r_buff_dout <= bus.img_rdata;
                        r_buff_addr <= r_index;
                        r_buff_wr   <= 1'b1;
                        r_state     <= S_RD_STROBE;
                    end
                end

                S_RD_STROBE: begin
                    r_buff_wr <= 1'b0;
                    if (w_last) begin
                        r_ack   <= 3'b000;
                        r_state <= S_RELEASE;
                    end else begin
                        r_index    <= w_index_next;
                        r_img_req  <= r_in_range;
                        r_img_addr <= {r_lba_base, w_index_next};
                        r_state    <= S_RD_FETCH;
                    end
                end

                S_WR_ADDR: begin
                    // Buffer data for r_buff_addr shows up on din during WR_STORE.
                    r_state <= S_WR_STORE;
                end

                S_WR_STORE: begin
                    // First cycle captures din; in range, the request then waits for img_ack.
                    if (!r_img_req) begin
                        r_img_wdata <= w_din;
                        r_img_addr  <= {r_lba_base, r_index};
                        if (r_in_range) begin
                            r_img_req <= 1'b1;
                            r_img_we  <= 1'b1;
                        end else if (w_last) begin
                            r_ack   <= 3'b000;
                            r_state <= S_RELEASE;
                        end else begin
                            r_index     <= w_index_next;
                            r_buff_addr <= w_index_next;
                            r_state     <= S_WR_ADDR;
                        end
                    end else if (bus.img_ack) begin
                        r_img_req <= 1'b0;
                        r_img_we  <= 1'b0;
                        if (w_last) begin
                            r_ack   <= 3'b000;
                            r_state <= S_RELEASE;
                        end else begin
                            r_index     <= w_index_next;
                            r_buff_addr <= w_index_next;
                            r_state     <= S_WR_ADDR;
                        end
                    end
                end

                S_RELEASE: begin
                    // Wait for the served drive to drop its level so it cannot retrigger.
                    if (!w_drv_active) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sd_ack       = r_ack;
    assign bus.sd_buff_addr = r_buff_addr;
    assign bus.sd_buff_dout = r_buff_dout;
    assign bus.sd_buff_wr   = r_buff_wr;
    assign bus.img_req      = r_img_req;
    assign bus.img_we       = r_img_we;
    assign bus.img_drive    = r_img_drive;
    assign bus.img_addr     = r_img_addr;
    assign bus.img_wdata    = r_img_wdata;
    assign bus.busy         = r_busy;

endmodule

// File: doc/sd_block_responder.md
SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 4, meaning cycles between sd_ack rise and first byte action (range 1..15).
REQ-002 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sd_rd  input  3  per-drive 512-byte block read request, level.
REQ-005 SHALL have port sd_wr  input  3  per-drive block write request, level.
REQ-006 SHALL have ports sd_lba0, sd_lba1, sd_lba2  input  32 each  block number per drive.
REQ-007 SHALL have ports img_blocks0, img_blocks1, img_blocks2  input  32 each  image size in blocks; 0 = unmounted.
REQ-008 SHALL have ports sd_buff_din0, sd_buff_din1, sd_buff_din2  input  8 each  requester buffer read data, valid 1 cycle after sd_buff_addr.
REQ-009 SHALL have port sd_ack  output  3  one-hot transfer-in-progress flag for the drive being served.
REQ-010 SHALL have port sd_buff_addr  output  9  byte index within block.
REQ-011 SHALL have port sd_buff_dout  output  8  read data to requester.
REQ-012 SHALL have port sd_buff_wr  output  1  one-cycle strobe writing sd_buff_dout at sd_buff_addr.
REQ-013 SHALL have ports img_req output 1, img_we output 1, img_drive output 2, img_addr output 32 (lba*512+index, mod 2^32), img_wdata output 8  backing-store request.
REQ-014 SHALL have ports img_ack input 1 (one-cycle completion), img_rdata input 8 (valid with img_ack).
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ACK_WAIT, RD_FETCH, RD_STROBE, WR_ADDR, WR_STORE, RELEASE.
REQ-017 IDLE: when any sd_rd|sd_wr bit is set, SHALL select the lowest-index such drive, latch its lba and blocks, and set op = read if sd_rd[d] else write (read wins when both are set).
REQ-018 On that selection SHALL, next cycle, drive sd_ack[d]=1, clear the byte index to 0, load a delay counter with ACK_DELAY, and enter ACK_WAIT.
REQ-019 ACK_WAIT SHALL decrement the delay counter, then enter RD_FETCH (read) or WR_ADDR (write) when it reaches 0.
REQ-020 In-range check: lba < blocks (32-bit unsigned compare, latched at selection).
REQ-021 RD_FETCH, in range: SHALL hold img_req=1, img_we=0 until the img_ack cycle, then latch img_rdata and enter RD_STROBE; out of range: no img_req, data=0x00, enter RD_STROBE next cycle.
REQ-022 RD_STROBE SHALL assert sd_buff_wr=1 for exactly one cycle with sd_buff_addr=index and sd_buff_dout=data; then index+1 and RD_FETCH, or RELEASE if index was 511.
REQ-023 WR_ADDR SHALL present sd_buff_addr=index for one cycle; WR_STORE SHALL capture sd_buff_din[d] into img_wdata and, if in range, hold img_req=1, img_we=1 until img_ack; out of range: discard, 1 cycle.
REQ-024 After WR_STORE SHALL increment index and return to WR_ADDR, or enter RELEASE after index 511.
REQ-025 RELEASE SHALL clear sd_ack in its first cycle and return to IDLE only once sd_rd[d] and sd_wr[d] are both 0 (no retrigger on a stale level).
REQ-026 Changes to sd_rd/sd_wr/sd_lba during a transfer SHALL be ignored; other drives wait until IDLE.
REQ-027 The index SHALL be 9 bits; exactly 512 strobes or stores SHALL occur per transfer, none duplicated or skipped.
REQ-028 img_drive SHALL equal the latched drive whenever img_req=1; img_req SHALL never be high in IDLE, ACK_WAIT, RELEASE.

Reset
REQ-029 On reset, including mid-transfer, next cycle SHALL yield state IDLE, sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0, img_req=0, img_we=0, img_drive=0, img_addr=0, img_wdata=0, busy=0.
REQ-030 A request held through reset SHALL be served from byte 0 after reset releases.

Verification
REQ-031 sd_rd=3'b010, lba1=5, blocks1=10, store returns addr&0xFF with 2-cycle img_ack -> sd_ack=3'b010, 512 strobes with dout=index[7:0], img_addr 0xA00..0xBFF, ack drops, busy low after sd_rd clears.
REQ-032 sd_wr=3'b001, lba0=0, din0 = ~addr -> 512 img writes, img_wdata = ~index[7:0], img_addr 0..511.
REQ-033 sd_rd=3'b001, lba0=10, blocks0=10 -> no img_req, 512 strobes with dout=0x00; write variant -> no img_req, 512 WR_STORE cycles.
REQ-034 sd_rd=3'b101 simultaneous -> drive 0 served first, drive 2 after drive-0 sd_rd drops; sd_rd[0]&sd_wr[0] both set -> read performed.
REQ-035 Reset asserted at byte 200 of a read -> all outputs 0 next cycle; held sd_rd restarts at byte 0.
REQ-036 sd_rd held high after completion -> module stays in RELEASE with sd_ack=0, no second transfer.
